// File: rtl/pipe_stage_skid.sv
// EX->MEM pipeline stage: main register plus one skid entry behind a registered ready,
// with flush, NOP-to-bubble conversion at capture and saturating stall/bubble counters.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_aux,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [REG_W-1:0]  in_wreg,
  input  logic              in_zero,
  input  logic              nop,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_aux,
  output logic [DATA_W-1:0] out_wdata,
  output logic [REG_W-1:0]  out_wreg,
  output logic              out_zero,
  output logic              out_bubble,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] aux;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  wreg;
    logic              zero;
    logic              bubble;
  } ent_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ent_t             w_cap, r_main, r_skid;
  logic             r_main_vld, r_skid_vld;
  logic             w_acc, w_drn, w_bub_inc, w_stall_inc;
  logic [CNT_W-1:0] r_bubble_cnt, r_stall_cnt;

  // NOP keeps pc/aux so branch-target bookkeeping survives the bubble
  always_comb begin
    w_cap.pc     = in_pc;
    w_cap.aux    = in_aux;
    w_cap.data   = nop ? '0 : in_data;
    w_cap.wdata  = nop ? '0 : in_wdata;
    w_cap.wreg   = nop ? '0 : in_wreg;
    w_cap.zero   = nop ? 1'b0 : in_zero;
    w_cap.bubble = nop;
  end

  assign in_ready    = !r_skid_vld;
  assign w_acc       = in_valid & in_ready;
  assign w_drn       = r_main_vld & out_ready;
  assign w_bub_inc   = w_acc & nop & !flush;
  assign w_stall_inc = r_main_vld & !out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (flush) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (!r_main_vld || w_drn) begin
      if (r_skid_vld) begin
        r_main     <= r_skid;
        r_main_vld <= 1'b1;
        r_skid_vld <= w_acc;
        if (w_acc) r_skid <= w_cap;
      end else if (w_acc) begin
        r_main     <= w_cap;
        r_main_vld <= 1'b1;
      end else begin
        r_main_vld <= 1'b0;
      end
    end else if (w_acc) begin
      r_skid     <= w_cap;
      r_skid_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_bub_inc && r_bubble_cnt != CNT_MAX) r_bubble_cnt <= r_bubble_cnt + 1'b1;
      if (w_stall_inc && r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Write-back must never see a stale destination from an empty stage
  assign out_valid  = r_main_vld;
  assign out_pc     = r_main.pc;
  assign out_data   = r_main.data;
  assign out_aux    = r_main.aux;
  assign out_wdata  = r_main.wdata;
  assign out_wreg   = r_main_vld ? r_main.wreg : '0;
  assign out_zero   = r_main.zero;
  assign out_bubble = r_main.bubble;
  assign bubble_cnt = r_bubble_cnt;
  assign stall_cnt  = r_stall_cnt;

endmodule
